// File: rtl/load_queue.sv
// In-order load queue between the ACU and data memory / CDB: holds DEPTH computed
// loads and issues the oldest when no older stores are pending. Optional same-cycle
// bypass of an empty queue is enabled by defining LQ_BYPASS_EN.
module load_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       alloc_valid,
    input  logic [ADDR_W-1:0]          alloc_address,
    input  logic [TAG_W-1:0]           alloc_rob_tag,
    input  logic [2:0]                 alloc_mem_size,
    input  logic                       pending_stores,
    input  logic                       exec_stall,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       read_mem,
    output logic [ADDR_W-1:0]          load_address,
    output logic [TAG_W-1:0]           load_rob_tag,
    output logic [2:0]                 load_mem_size,
    output logic                       out_valid
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Handshakes: an allocation transfers when alloc_valid && !full (full is the
    // ACU's not-ready); an issue transfers when read_mem && !exec_stall, and
    // out_valid marks that transfer. An unaccepted request must be held unchanged.

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [2:0]        size_q [DEPTH];

    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_next;

    logic queue_issue;
    logic bypass;
    logic enq;
    logic deq;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    assign queue_issue = !empty && !pending_stores && !flush;
    assign deq         = queue_issue && !exec_stall;

`ifdef LQ_BYPASS_EN
    // An empty queue with a free memory slot hands the incoming load straight through.
    assign bypass = empty && alloc_valid && !pending_stores && !exec_stall && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign enq       = alloc_valid && !full && !flush && !bypass;
    assign read_mem  = queue_issue || bypass;
    assign out_valid = deq || bypass;

    always_comb begin
        load_address  = '0;
        load_rob_tag  = '0;
        load_mem_size = '0;
        if (bypass) begin
            load_address  = alloc_address;
            load_rob_tag  = alloc_rob_tag;
            load_mem_size = alloc_mem_size;
        end else if (!empty) begin
            load_address  = addr_q[head_ptr];
            load_rob_tag  = tag_q[head_ptr];
            load_mem_size = size_q[head_ptr];
        end
    end

    always_comb begin
        count_next = count_q;
        if (enq && !deq) begin
            count_next = count_q + CNT_W'(1);
        end else if (deq && !enq) begin
            count_next = count_q - CNT_W'(1);
        end
    end

    // Pointers are exactly PTR_W bits, so DEPTH being a power of two makes them wrap for free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                tag_q[i]  <= '0;
                size_q[i] <= '0;
            end
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                tag_q[i]  <= '0;
                size_q[i] <= '0;
            end
        end else begin
            if (enq) begin
                addr_q[tail_ptr] <= alloc_address;
                tag_q[tail_ptr]  <= alloc_rob_tag;
                size_q[tail_ptr] <= alloc_mem_size;
                tail_ptr         <= tail_ptr + PTR_W'(1);
            end
            if (deq) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            count_q <= count_next;
        end
    end

endmodule

// File: tb/tb_load_queue.sv
// Self-checking bench for load_queue: per-scenario tasks with inline checks plus a
// scoreboard that matches every issued load against the expected FIFO order.
module tb_load_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int TAG_W  = 5;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int EW     = 3 + TAG_W + ADDR_W;

    logic              clock;
    logic              reset_n;
    logic              flush;
    logic              alloc_valid;
    logic [ADDR_W-1:0] alloc_address;
    logic [TAG_W-1:0]  alloc_rob_tag;
    logic [2:0]        alloc_mem_size;
    logic              pending_stores;
    logic              exec_stall;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              read_mem;
    logic [ADDR_W-1:0] load_address;
    logic [TAG_W-1:0]  load_rob_tag;
    logic [2:0]        load_mem_size;
    logic              out_valid;

    int n_checks = 0;
    int n_fail   = 0;
    logic sb_on  = 1'b0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] sb_got;
    logic [EW-1:0] sb_exp;

    load_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .flush          (flush),
        .alloc_valid    (alloc_valid),
        .alloc_address  (alloc_address),
        .alloc_rob_tag  (alloc_rob_tag),
        .alloc_mem_size (alloc_mem_size),
        .pending_stores (pending_stores),
        .exec_stall     (exec_stall),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .read_mem       (read_mem),
        .load_address   (load_address),
        .load_rob_tag   (load_rob_tag),
        .load_mem_size  (load_mem_size),
        .out_valid      (out_valid)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard: every issued load must be the oldest expected one.
    always @(negedge clock) begin
        if (sb_on && reset_n && out_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_issue: got address %h tag %0d, required no issue",
                         load_address, load_rob_tag);
            end else begin
                sb_got = {load_mem_size, load_rob_tag, load_address};
                sb_exp = exp_q.pop_front();
                if (sb_got !== sb_exp) begin
                    n_fail++;
                    $display("FAIL sb_order: got {size,tag,addr}=%h, required %h", sb_got, sb_exp);
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        alloc_valid    = 1'b0;
        alloc_address  = '0;
        alloc_rob_tag  = '0;
        alloc_mem_size = '0;
        flush          = 1'b0;
    endtask

    task automatic drive_alloc(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t,
                               input logic [2:0] s);
        alloc_valid    = 1'b1;
        alloc_address  = a;
        alloc_rob_tag  = t;
        alloc_mem_size = s;
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t,
                            input logic [2:0] s);
        exp_q.push_back({s, t, a});
    endtask

    // Scenarios
    task automatic test_reset();
        reset_n = 1'b0;
        pending_stores = 1'b0;
        exec_stall = 1'b0;
        drive_idle();
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b, required 0", full); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b, required 1", empty); end
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", count); end
        reset_n = 1'b1;
        #1;
        n_checks++; if (read_mem !== 1'b0) begin n_fail++; $display("FAIL reset_read_mem: got %b, required 0", read_mem); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_checks++; if (load_address !== '0) begin n_fail++; $display("FAIL reset_load_address: got %h, required 0", load_address); end
        tick();
    endtask

    task automatic test_reset_mid();
        pending_stores = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_alloc(32'h40 + 32'(4 * i), TAG_W'(i), 3'b010);
            tick();
        end
        drive_idle();
        #1;
        n_checks++; if (count !== CNT_W'(3)) begin n_fail++; $display("FAIL rmid_count_before: got %0d, required 3", count); end
        pending_stores = 1'b0;
        reset_n = 1'b0;
        #1;
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL rmid_count: got %0d, required 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rmid_empty: got %b, required 1", empty); end
        n_checks++; if (read_mem !== 1'b0) begin n_fail++; $display("FAIL rmid_read_mem: got %b, required 0", read_mem); end
        n_checks++; if (load_address !== '0) begin n_fail++; $display("FAIL rmid_load_address: got %h, required 0", load_address); end
        #1;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        pending_stores = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive_alloc(32'h100 + 32'(4 * i), TAG_W'(i + 1), 3'(i));
            push_exp(32'h100 + 32'(4 * i), TAG_W'(i + 1), 3'(i));
            #1;
            n_checks++; if (count !== CNT_W'(i)) begin n_fail++; $display("FAIL fill_count: got %0d, required %0d", count, i); end
            tick();
        end
        drive_alloc(32'h110, TAG_W'(9), 3'b000);
        #1;
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b, required 1", full); end
        n_checks++; if (count !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL fill_count4: got %0d, required %0d", count, DEPTH); end
        tick();
        n_checks++; if (count !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL fill_ignored: got %0d, required %0d", count, DEPTH); end
        // ACU keeps requesting while the head drains: still rejected because full.
        pending_stores = 1'b0;
        drive_alloc(32'h114, TAG_W'(10), 3'b001);
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_drain0: got %b, required 1", out_valid); end
        tick();
        drive_idle();
        #1;
        n_checks++; if (count !== CNT_W'(DEPTH - 1)) begin n_fail++; $display("FAIL fill_full_deq: got %0d, required %0d", count, DEPTH - 1); end
        for (int i = 1; i < DEPTH; i++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_drain%0d: got %b, required 1", i, out_valid); end
            tick();
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty: got %b, required 1", empty); end
        n_checks++; if (read_mem !== 1'b0) begin n_fail++; $display("FAIL fill_read_mem: got %b, required 0", read_mem); end
    endtask

    task automatic test_stall();
        pending_stores = 1'b0;
        exec_stall = 1'b1;
        drive_alloc(32'h180, TAG_W'(7), 3'b100);
        push_exp(32'h180, TAG_W'(7), 3'b100);
        #1;
        n_checks++; if (read_mem !== 1'b0) begin n_fail++; $display("FAIL stall_alloc_cycle: got %b, required 0", read_mem); end
        tick();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (read_mem !== 1'b1) begin n_fail++; $display("FAIL stall_read_mem: got %b, required 1", read_mem); end
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_out_valid: got %b, required 0", out_valid); end
            n_checks++; if (load_rob_tag !== TAG_W'(7)) begin n_fail++; $display("FAIL stall_tag: got %0d, required 7", load_rob_tag); end
            tick();
        end
        exec_stall = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b, required 1", out_valid); end
        tick();
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL stall_empty: got %b, required 1", empty); end
    endtask

    task automatic test_back_to_back();
        logic exp_ov;
        logic [CNT_W-1:0] exp_cnt;
        pending_stores = 1'b0;
        exec_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_alloc(32'h400 + 32'(4 * i), TAG_W'(i + 10), 3'(i));
            push_exp(32'h400 + 32'(4 * i), TAG_W'(i + 10), 3'(i));
`ifdef LQ_BYPASS_EN
            exp_ov = 1'b1;
            exp_cnt = '0;
`else
            exp_ov = (i > 0);
            exp_cnt = CNT_W'(1);
`endif
            #1;
            n_checks++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL b2b_out_valid%0d: got %b, required %b", i, out_valid, exp_ov); end
            tick();
            n_checks++; if (count !== exp_cnt) begin n_fail++; $display("FAIL b2b_count%0d: got %0d, required %0d", i, count, exp_cnt); end
        end
        drive_idle();
`ifdef LQ_BYPASS_EN
        exp_ov = 1'b0;
`else
        exp_ov = 1'b1;
`endif
        #1;
        n_checks++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL b2b_last: got %b, required %b", out_valid, exp_ov); end
        tick();
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b, required 1", empty); end
    endtask

    task automatic test_flush();
        pending_stores = 1'b1;
        drive_alloc(32'h1C0, TAG_W'(20), 3'b010);
        tick();
        drive_alloc(32'h1C4, TAG_W'(21), 3'b010);
        tick();
        pending_stores = 1'b0;
        flush = 1'b1;
        drive_alloc(32'h200, TAG_W'(22), 3'b010);
        #1;
        n_checks++; if (read_mem !== 1'b0) begin n_fail++; $display("FAIL flush_read_mem: got %b, required 0", read_mem); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b, required 0", out_valid); end
        tick();
        drive_idle();
        #1;
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL flush_count: got %0d, required 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b, required 1", empty); end
        tick();
        tick();
        drive_alloc(32'h240, TAG_W'(23), 3'b101);
        push_exp(32'h240, TAG_W'(23), 3'b101);
        tick();
        drive_idle();
        #1;
`ifdef LQ_BYPASS_EN
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_reuse: got empty %b, required 1", empty); end
`else
        n_checks++; if (load_address !== 32'h240) begin n_fail++; $display("FAIL flush_reuse: got %h, required 00000240", load_address); end
`endif
        tick();
    endtask

    task automatic test_bypass();
        pending_stores = 1'b0;
        exec_stall = 1'b0;
        drive_alloc(32'h300, TAG_W'(3), 3'b010);
        push_exp(32'h300, TAG_W'(3), 3'b010);
        #1;
`ifdef LQ_BYPASS_EN
        n_checks++; if (read_mem !== 1'b1) begin n_fail++; $display("FAIL byp_read_mem: got %b, required 1", read_mem); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL byp_out_valid: got %b, required 1", out_valid); end
        n_checks++; if (load_address !== 32'h300) begin n_fail++; $display("FAIL byp_address: got %h, required 00000300", load_address); end
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL byp_count: got %0d, required 0", count); end
        tick();
        drive_idle();
`else
        n_checks++; if (read_mem !== 1'b0) begin n_fail++; $display("FAIL nobyp_read_mem0: got %b, required 0", read_mem); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nobyp_out_valid0: got %b, required 0", out_valid); end
        tick();
        drive_idle();
        #1;
        n_checks++; if (read_mem !== 1'b1) begin n_fail++; $display("FAIL nobyp_read_mem1: got %b, required 1", read_mem); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nobyp_out_valid1: got %b, required 1", out_valid); end
        n_checks++; if (load_address !== 32'h300) begin n_fail++; $display("FAIL nobyp_address: got %h, required 00000300", load_address); end
        tick();
`endif
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL byp_empty: got %b, required 1", empty); end
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        sb_on = 1'b1;
        test_reset_mid();
        test_fill();
        test_stall();
        test_back_to_back();
        test_flush();
        test_bypass();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d loads never issued, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
